ex_muldiv_unit: RTL and testbench

//  EX-stage consumer of the ID/EX pipeline outputs for RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_defs.sv | 21 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_defs.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encodings and the default datapath width.
package muldiv_defs;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide. acc = {high half, low half}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted_hi;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum        = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted_hi = acc_i[2*XLEN-1:XLEN-1];
    qbit_o     = (shifted_hi >= {1'b0, operand_i});
    // When the subtract succeeds the true difference is below the divisor,
    // so the modular XLEN-bit difference is exact.
    diff       = shifted_hi[XLEN-1:0] - operand_i;
    if (div_i) begin
      acc_o = {(qbit_o ? diff : shifted_hi[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX: one bit per cycle, busy_o
// stalls the front end, done_o pulses once with the result for EX/MEM.
module ex_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, fast_val;
  logic [2*XLEN-1:0] step_acc, prod;
  logic              step_qbit;
  logic [XLEN-1:0]   quo, rem, final_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .div_i     (op_q[2]),
    .acc_o     (step_acc),
    .qbit_o    (step_qbit)
  );

  // Operand decode for an op arriving from ID/EX.
  always_comb begin
    a_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    b_signed = a_signed && (op_i != OP_MULHSU);
    sa       = a_signed & rs1_data_i[XLEN-1];
    sb       = b_signed & rs2_data_i[XLEN-1];
    abs_a    = sa ? -rs1_data_i : rs1_data_i;
    abs_b    = sb ? -rs2_data_i : rs2_data_i;
    div_zero = (rs2_data_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
    fast_val = div_zero ? (op_i[1] ? rs1_data_i : '1) : (op_i[1] ? '0 : rs1_data_i);
  end

  // Sign fix of the magnitude result; FAST results are already final.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
    if (state_q == S_FAST) final_res = acc_q[XLEN-1:0];
  end

  assign busy_o    = (state_q == S_BUSY);
  assign done_o    = ((state_q == S_DONE) || (state_q == S_FAST)) && !kill_i && !rst;
  assign result_o  = done_o ? final_res : result_q;
  assign rd_addr_o = done_o ? rd_q : rd_out_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          op_d   = op_i;
          rd_d   = rd_addr_i;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          cnt_d  = '0;
          if (op_i[2] && (div_zero || div_ovf)) begin
            state_d = S_FAST;
            acc_d   = {{XLEN{1'b0}}, fast_val};
          end else begin
            state_d = S_BUSY;
            acc_d   = {{XLEN{1'b0}}, (op_i[2] ? abs_a : abs_b)};
            opnd_d  = op_i[2] ? abs_b : abs_a;
          end
        end
      end
      S_BUSY: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? {step_acc[2*XLEN-1:1], step_qbit} : step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (done_o) begin
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec cases, randomized ops
// against a 64-bit arithmetic reference, kill/reset/stall scenarios.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start_i, kill_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .kill_i     (kill_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa_l, sb_l, ua_l, ub_l;
    logic [63:0] p;
    logic ovf;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua_l = longint'({32'h0, a});
    ub_l = longint'({32'h0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa_l * sb_l); return p[31:0]; end
      3'd1: begin p = 64'(sa_l * sb_l); return p[63:32]; end
      3'd2: begin p = 64'(sa_l * ub_l); return p[63:32]; end
      3'd3: begin p = 64'(ua_l * ub_l); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Presents one op and observes it until done_o (bounded to 40 cycles).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output int busy_cycles,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output logic done_after, output logic overlap);
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b0; op_i = op;
    rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    lat = -1; busy_cycles = 0; res = 'x; rdo = 'x; overlap = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o) busy_cycles++;
      if (busy_o && done_o) overlap = 1'b1;
      if (done_o) begin lat = c; res = result_o; rdo = rd_addr_o; end
    end
    @(negedge clk);
    done_after = done_o;
  endtask

  task automatic exercise_op(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat, busy_cycles, exp_lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic done_after, overlap;
    exp_lat = ref_latency(op, a, b);
    issue(op, a, b, rd, lat, busy_cycles, res, rdo, done_after, overlap);
    checks++;
    if (res !== exp) begin errors++; $display("FAIL %s result op=%0d a=%h b=%h: got %h expected %h", name, op, a, b, res, exp); end
    checks++;
    if (rdo !== rd) begin errors++; $display("FAIL %s rd_addr: got %0d expected %0d", name, rdo, rd); end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++;
    if (busy_cycles != ((exp_lat == 1) ? 0 : 32)) begin
      errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cycles, (exp_lat == 1) ? 0 : 32);
    end
    checks++;
    if (done_after !== 1'b0) begin errors++; $display("FAIL %s done pulse width: got %b expected 0 one cycle later", name, done_after); end
    checks++;
    if (overlap !== 1'b0) begin errors++; $display("FAIL %s busy and done both high", name); end
    if (lat == exp_lat) begin prev_res = res; prev_rd = rdo; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset busy/done: got %b expected 00", {busy_o, done_o}); end
    checks++;
    if (result_o !== 32'h0) begin errors++; $display("FAIL reset result: got %h expected 0", result_o); end
    checks++;
    if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset rd_addr: got %0d expected 0", rd_addr_o); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  d_op  [12];
    logic [31:0] d_a   [12];
    logic [31:0] d_b   [12];
    logic [31:0] d_exp [12];
    d_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    d_a   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    d_b   = '{32'hFFFF_FFFD, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    d_exp = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 12; i++) begin
      exercise_op($sformatf("directed%0d", i), d_op[i], d_a[i], d_b[i], 5'(i + 3), d_exp[i]);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       begin b = $urandom; a = 32'($urandom_range(0, 300)); end
        default: b = $urandom;
      endcase
      exercise_op($sformatf("random%0d", i), op, a, b, 5'($urandom_range(0, 31)), ref_model(op, a, b));
    end
  endtask

  task automatic test_kill();
    int dones;
    exercise_op("kill_setup", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    // Kill in cycle 10 of a long divide.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd7; rd_addr_i = 5'd9;
    for (int c = 1; c <= 9; c++) begin @(negedge clk); start_i = 1'b0; end
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL kill_busy idle after kill: got %b expected 00", {busy_o, done_o}); end
    checks++;
    if (result_o !== prev_res || rd_addr_o !== prev_rd) begin
      errors++; $display("FAIL kill_busy held result: got %h/%0d expected %h/%0d", result_o, rd_addr_o, prev_res, prev_rd);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (done_o) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL kill_busy stray done: got %0d expected 0", dones); end
    // start and kill together: nothing accepted.
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd50; rs2_data_i = 32'd3; rd_addr_i = 5'd2;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_start busy: got %b expected 0", busy_o); end
    dones = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (done_o || busy_o) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL kill_start activity cycles: got %0d expected 0", dones); end
    // Kill during the FAST cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'd5; rs2_data_i = 32'd0; rd_addr_i = 5'd11;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b1;
    #1;
    checks++;
    if (done_o !== 1'b0 || result_o !== prev_res) begin
      errors++; $display("FAIL kill_fast: got done=%b res=%h expected done=0 res=%h", done_o, result_o, prev_res);
    end
    @(negedge clk);
    kill_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== prev_res || rd_addr_o !== prev_rd) begin
      errors++; $display("FAIL kill_fast after: got done=%b busy=%b res=%h rd=%0d expected 0 0 %h %0d", done_o, busy_o, result_o, rd_addr_o, prev_res, prev_rd);
    end
    // Kill in the DONE cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd5; rd_addr_i = 5'd4;
    for (int c = 1; c <= 32; c++) begin @(negedge clk); start_i = 1'b0; end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL kill_done timing: done at cycle 33 got %b expected 1", done_o); end
    kill_i = 1'b1;
    #1;
    checks++;
    if (done_o !== 1'b0 || result_o !== prev_res) begin
      errors++; $display("FAIL kill_done suppress: got done=%b res=%h expected done=0 res=%h", done_o, result_o, prev_res);
    end
    @(negedge clk);
    kill_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== prev_res || rd_addr_o !== prev_rd) begin
      errors++; $display("FAIL kill_done after: got done=%b busy=%b res=%h rd=%0d expected 0 0 %h %0d", done_o, busy_o, result_o, rd_addr_o, prev_res, prev_rd);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd12345; rs2_data_i = 32'd678; rd_addr_i = 5'd21;
    for (int c = 1; c <= 19; c++) begin @(negedge clk); start_i = 1'b0; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
      errors++; $display("FAIL reset_mid outputs: got busy=%b done=%b res=%h rd=%0d expected all 0", busy_o, done_o, result_o, rd_addr_o);
    end
    rst = 1'b0;
    exercise_op("after_reset", 3'd0, 32'hFFFF_FF00, 32'd300, 5'd6, ref_model(3'd0, 32'hFFFF_FF00, 32'd300));
  endtask

  // start_i held high with changing operands while busy must be ignored.
  task automatic test_back_to_back();
    int busy_cycles, dones;
    logic [31:0] exp;
    exp = ref_model(3'd6, 32'hFFFF_D8F1, 32'd37);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd6; rs1_data_i = 32'hFFFF_D8F1; rs2_data_i = 32'd37; rd_addr_i = 5'd30;
    busy_cycles = 0; dones = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (busy_o) busy_cycles++;
      if (done_o) dones++;
      op_i = 3'($urandom_range(0, 7)); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_cycles != 32 || dones != 0) begin
      errors++; $display("FAIL b2b busy window: got busy=%0d done=%0d expected 32 0", busy_cycles, dones);
    end
    checks++;
    if (done_o !== 1'b1 || result_o !== exp || rd_addr_o !== 5'd30) begin
      errors++; $display("FAIL b2b result: got done=%b res=%h rd=%0d expected 1 %h 30", done_o, result_o, rd_addr_o, exp);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL b2b after: got done=%b busy=%b expected 0 0", done_o, busy_o); end
    exercise_op("b2b_next", 3'd5, 32'hFFFF_FFFF, 32'd10, 5'd1, ref_model(3'd5, 32'hFFFF_FFFF, 32'd10));
  endtask

  initial begin
    prev_res = '0;
    prev_rd  = '0;
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
